// File: rtl/fg_cpu_if.sv
// Z80-side bus bundle for the foreground RAM access controller.
// The CPU decode drives the master side; fg_cpu_access sits on the slave side.
interface fg_cpu_if #(
  parameter int AW = 11
);
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_cs_chr_n;
  logic          cpu_cs_atr_n;
  logic          cpu_wr_n;
  logic          cpu_rd_n;
  logic [7:0]    cpu_dout;
  logic          cpu_wait_n;

  modport master (
    output cpu_addr, cpu_din, cpu_cs_chr_n, cpu_cs_atr_n, cpu_wr_n, cpu_rd_n,
    input  cpu_dout, cpu_wait_n
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_cs_chr_n, cpu_cs_atr_n, cpu_wr_n, cpu_rd_n,
    output cpu_dout, cpu_wait_n
  );
endinterface

// File: rtl/fg_cpu_access.sv
// Z80 access controller for the foreground CHARAM/ATRRAM port B: one RAM
// operation per bus cycle, issued in the video CPU slot, with WAIT held meanwhile.
module fg_cpu_access #(
  parameter int AW          = 11,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          master_clk,
  input  logic          reset_n,
  input  logic          slot_free,
  fg_cpu_if.slave       cpu,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we_chr,
  output logic          ram_we_atr,
  input  logic [7:0]    ram_q_chr,
  input  logic [7:0]    ram_q_atr,
  output logic          timeout_err
);

  typedef enum logic [2:0] {IDLE, ARM, ACCESS, CAPTURE, HOLD, DONE} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [2:0] HOLD_LAST = 3'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  state_t        state, state_nxt;
  logic          req;
  logic          latch, capture, tmo_force;
  logic [7:0]    tmo_cnt;
  logic [2:0]    hold_cnt;
  logic          plane_chr, is_wr;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q, dout_q;
  logic          err_q;

  assign req = (!cpu.cpu_cs_chr_n || !cpu.cpu_cs_atr_n) && (!cpu.cpu_wr_n || !cpu.cpu_rd_n);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    capture   = 1'b0;
    tmo_force = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch     = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (slot_free) begin
          state_nxt = ACCESS;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ACCESS;
          tmo_force = 1'b1;
        end
      end
      ACCESS: begin
        if (!is_wr)                 state_nxt = CAPTURE;
        else if (HOLD_CYCLES == 0)  state_nxt = DONE;
        else                        state_nxt = HOLD;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = (HOLD_CYCLES == 0) ? DONE : HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = DONE;
      end
      DONE: begin
        // Re-arming only after the strobe drops keeps a long bus cycle to one access.
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt   <= 8'h00;
      hold_cnt  <= 3'd0;
      plane_chr <= 1'b0;
      is_wr     <= 1'b0;
      addr_q    <= '0;
      din_q     <= 8'h00;
      dout_q    <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      if (latch) begin
        tmo_cnt   <= 8'h00;
        plane_chr <= !cpu.cpu_cs_chr_n;
        is_wr     <= !cpu.cpu_wr_n;
        addr_q    <= cpu.cpu_addr;
        din_q     <= cpu.cpu_din;
      end else if (state == ARM && tmo_cnt != 8'hFF) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (state != HOLD)             hold_cnt <= 3'd0;
      else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 3'd1;

      if (capture)   dout_q <= plane_chr ? ram_q_chr : ram_q_atr;
      if (tmo_force) err_q  <= 1'b1;
    end
  end

  // Write enables decode straight from state so an async reset kills them at once.
  assign ram_we_chr  = (state == ACCESS) && is_wr && plane_chr;
  assign ram_we_atr  = (state == ACCESS) && is_wr && !plane_chr;
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign timeout_err = err_q;

  assign cpu.cpu_dout   = dout_q;
  assign cpu.cpu_wait_n = !(req && state == IDLE) && (state == IDLE || state == DONE);

endmodule

// File: tb/tb_fg_cpu_access.sv
// Directed bench for fg_cpu_access with HOLD_CYCLES=2 and TIMEOUT=16.
module tb_fg_cpu_access;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          slot_free;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we_chr, ram_we_atr;
  logic [7:0]    ram_q_chr, ram_q_atr;
  logic          timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  int chr_pulses = 0;
  int atr_pulses = 0;
  int base_chr, base_atr, wait_lows;

  fg_cpu_if #(.AW(AW)) bus ();

  fg_cpu_access #(.AW(AW), .HOLD_CYCLES(2), .TIMEOUT(16)) dut (
    .master_clk (clk),
    .reset_n    (reset_n),
    .slot_free  (slot_free),
    .cpu        (bus),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we_chr (ram_we_chr),
    .ram_we_atr (ram_we_atr),
    .ram_q_chr  (ram_q_chr),
    .ram_q_atr  (ram_q_atr),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model: known contents only at the addresses the bench reads.
  always @(posedge clk) begin
    ram_q_chr <= (ram_addr == 11'h123) ? 8'h3C : 8'hEE;
    ram_q_atr <= (ram_addr == 11'h7FF) ? 8'hC3 : 8'h11;
  end

  always @(negedge clk) begin
    if (ram_we_chr) chr_pulses++;
    if (ram_we_atr) atr_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cpu_cs_chr_n = 1'b1;
    bus.cpu_cs_atr_n = 1'b1;
    bus.cpu_wr_n     = 1'b1;
    bus.cpu_rd_n     = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    slot_free    = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = 8'h00;
    bus_idle();
    step();
    step();
    chk("rst_wait_n", bus.cpu_wait_n, 1);
    chk("rst_we_chr", ram_we_chr, 0);
    chk("rst_we_atr", ram_we_atr, 0);
    chk("rst_dout",   bus.cpu_dout, 8'h00);
    chk("rst_addr",   ram_addr, 0);
    chk("rst_din",    ram_din, 8'h00);
    chk("rst_err",    timeout_err, 0);
    reset_n = 1'b1;
    step();

    // CHARAM write, slot_free 4 cycles after req
    base_chr = chr_pulses; base_atr = atr_pulses;
    bus.cpu_addr = 11'h123; bus.cpu_din = 8'h5A;
    bus.cpu_cs_chr_n = 1'b0; bus.cpu_wr_n = 1'b0;
    #1 chk("wr_wait_req_cycle", bus.cpu_wait_n, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      slot_free = (c == 4);
      #1;
      if (c == 4) chk("wr_no_we_before_slot", ram_we_chr, 0);
      if (c == 5) begin
        chk("wr_we_chr", ram_we_chr, 1);
        chk("wr_addr", ram_addr, 11'h123);
        chk("wr_din", ram_din, 8'h5A);
      end
      if (c == 7) chk("wr_wait_held", bus.cpu_wait_n, 0);
      if (c == 8) chk("wr_wait_release", bus.cpu_wait_n, 1);
    end
    bus_idle();
    step();
    chk("wr_chr_pulses", chr_pulses - base_chr, 1);
    chk("wr_atr_pulses", atr_pulses - base_atr, 0);

    // ATRRAM read of 0x7FF
    base_chr = chr_pulses; base_atr = atr_pulses;
    bus.cpu_addr = 11'h7FF;
    bus.cpu_cs_atr_n = 1'b0; bus.cpu_rd_n = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      slot_free = (c == 4);
      #1;
      if (c == 6) chk("rd_dout_not_yet", bus.cpu_dout, 8'h00);
      if (c == 7) chk("rd_dout", bus.cpu_dout, 8'hC3);
      if (c == 8) chk("rd_wait_held", bus.cpu_wait_n, 0);
      if (c == 9) chk("rd_wait_release", bus.cpu_wait_n, 1);
    end
    bus_idle();
    step();
    chk("rd_no_we", (chr_pulses - base_chr) + (atr_pulses - base_atr), 0);

    // Timeout: no slot_free at all
    base_chr = chr_pulses;
    bus.cpu_addr = 11'h010; bus.cpu_din = 8'h77;
    bus.cpu_cs_chr_n = 1'b0; bus.cpu_wr_n = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 16) begin
        chk("tmo_no_we_early", ram_we_chr, 0);
        chk("tmo_err_early", timeout_err, 0);
      end
      if (c == 17) begin
        chk("tmo_forced_we", ram_we_chr, 1);
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_addr", ram_addr, 11'h010);
      end
      if (c == 19) chk("tmo_wait_held", bus.cpu_wait_n, 0);
      if (c == 20) chk("tmo_wait_release", bus.cpu_wait_n, 1);
    end
    bus_idle();
    step();
    chk("tmo_chr_pulses", chr_pulses - base_chr, 1);

    // Both selects low with a write: CHARAM wins
    base_chr = chr_pulses; base_atr = atr_pulses;
    bus.cpu_addr = 11'h055; bus.cpu_din = 8'hA5;
    bus.cpu_cs_chr_n = 1'b0; bus.cpu_cs_atr_n = 1'b0; bus.cpu_wr_n = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      slot_free = (c == 2);
      #1;
      if (c == 3) begin
        chk("both_we_chr", ram_we_chr, 1);
        chk("both_we_atr", ram_we_atr, 0);
      end
      if (c == 6) chk("both_wait_release", bus.cpu_wait_n, 1);
    end
    bus_idle();
    step();
    chk("both_chr_pulses", chr_pulses - base_chr, 1);
    chk("both_atr_pulses", atr_pulses - base_atr, 0);
    chk("err_sticky", timeout_err, 1);

    // Held bus cycle: req kept 20 cycles past DONE
    base_atr = atr_pulses;
    wait_lows = 0;
    bus.cpu_addr = 11'h200; bus.cpu_din = 8'h99;
    bus.cpu_cs_atr_n = 1'b0; bus.cpu_wr_n = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      step();
      slot_free = (c == 1);
      #1;
      if (c == 2) begin
        chk("held_we_atr", ram_we_atr, 1);
        chk("held_din", ram_din, 8'h99);
      end
      if (c >= 5 && !bus.cpu_wait_n) wait_lows++;
    end
    chk("held_wait_high", wait_lows, 0);
    chk("held_atr_pulses", atr_pulses - base_atr, 1);
    bus_idle();
    step();

    // New read after release; slot_free coinciding with req in IDLE is ignored
    bus.cpu_addr = 11'h123;
    bus.cpu_cs_chr_n = 1'b0; bus.cpu_rd_n = 1'b0;
    slot_free = 1'b1;
    #1 chk("rd2_wait_req_cycle", bus.cpu_wait_n, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      slot_free = (c == 3);
      #1;
      if (c == 5) chk("rd2_dout_held", bus.cpu_dout, 8'hC3);
      if (c == 6) chk("rd2_dout", bus.cpu_dout, 8'h3C);
      if (c == 7) chk("rd2_wait_held", bus.cpu_wait_n, 0);
      if (c == 8) chk("rd2_wait_release", bus.cpu_wait_n, 1);
    end
    bus_idle();
    step();

    // Reset asserted during ACCESS
    bus.cpu_addr = 11'h321; bus.cpu_din = 8'h42;
    bus.cpu_cs_chr_n = 1'b0; bus.cpu_wr_n = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      step();
      slot_free = (c == 1);
      #1;
    end
    chk("rst_mid_we_before", ram_we_chr, 1);
    reset_n = 1'b0;
    bus_idle();
    #1;
    chk("rst_mid_we_chr", ram_we_chr, 0);
    chk("rst_mid_wait_n", bus.cpu_wait_n, 1);
    chk("rst_mid_dout", bus.cpu_dout, 8'h00);
    chk("rst_mid_err", timeout_err, 0);
    chk("rst_mid_addr", ram_addr, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("rst_mid_idle_wait", bus.cpu_wait_n, 1);
    chk("rst_mid_idle_we", ram_we_chr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
